// File: rtl/uart_tx_fsm.sv
// ============================================================================
// Module   : uart_tx_fsm
// Function : Oversampled UART transmitter (start, 8 data LSB-first, parity,
//            stop) with a one-entry holding buffer for gap-free frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       baudOut,
  input  logic       rst,
  input  logic [7:0] dataIn,
  input  logic       dataValid,
  output logic       dataReady,
  output logic       serialOutput,
  output logic       busy,
  output logic       frameDone
);

  localparam int            CW     = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_idx, w_idx_n, w_idx_inc;
  logic [7:0]    r_shift, w_shift_n;
  logic [7:0]    r_buf, w_buf_n;
  logic          r_par, w_par_n;
  logic          r_full, w_full_n;
  logic          r_ser, w_ser_n;
  logic          r_busy, r_done, w_done_n;
  logic          r_ready;
  logic          w_last, w_load;

  assign w_last    = (r_cnt == C_LAST);
  assign w_idx_inc = r_idx + 3'd1;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_buf_n   = r_buf;
    w_par_n   = r_par;
    w_full_n  = r_full;
    w_ser_n   = 1'b1;
    w_done_n  = 1'b0;
    w_load    = 1'b0;

    // Tick counter is a power-of-two width, so it wraps to 0 by itself.
    if (r_state != S_IDLE) begin
      w_cnt_n = r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_ser_n = 1'b1;
        w_load  = r_full;
      end
      S_START: begin
        w_ser_n = 1'b0;
        if (w_last) begin
          w_state_n = S_DATA;
          w_idx_n   = 3'd0;
          w_ser_n   = r_shift[0];
        end
      end
      S_DATA: begin
        w_ser_n = r_shift[r_idx];
        if (w_last) begin
          if (r_idx == 3'd7) begin
            w_state_n = S_PARITY;
            w_ser_n   = r_par;
          end else begin
            w_idx_n = w_idx_inc;
            w_ser_n = r_shift[w_idx_inc];
          end
        end
      end
      S_PARITY: begin
        w_ser_n = r_par;
        if (w_last) begin
          w_state_n = S_STOP;
          w_ser_n   = 1'b1;
        end
      end
      S_STOP: begin
        w_ser_n = 1'b1;
        if (w_last) begin
          w_done_n = 1'b1;
          if (r_full) begin
            w_load = 1'b1;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase

    // Drain the holding buffer into the shifter; start bit goes out next cycle.
    if (w_load) begin
      w_shift_n = r_buf;
      w_par_n   = (^r_buf) ^ PARITY_ODD;
      w_full_n  = 1'b0;
      w_state_n = S_START;
      w_cnt_n   = '0;
      w_ser_n   = 1'b0;
    end

    // A drain needs a full buffer and an accept needs an empty one, so they never collide.
    if (dataValid && !r_full) begin
      w_buf_n  = dataIn;
      w_full_n = 1'b1;
    end
  end

  always_ff @(posedge baudOut or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_buf   <= 8'd0;
      r_par   <= 1'b0;
      r_full  <= 1'b0;
      r_ser   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_buf   <= w_buf_n;
      r_par   <= w_par_n;
      r_full  <= w_full_n;
      r_ser   <= w_ser_n;
      r_busy  <= (w_state_n != S_IDLE);
      r_done  <= w_done_n;
      r_ready <= !w_full_n;
    end
  end

  assign serialOutput = r_ser;
  assign busy         = r_busy;
  assign frameDone    = r_done;
  assign dataReady    = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
// ============================================================================
// Module   : tb_uart_tx_fsm
// Function : Bench for uart_tx_fsm (even and odd parity instances side by side).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fsm;

  localparam int OS = 16;
  localparam int FL = 11 * OS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'd0;
  logic       dv  = 1'b0;

  logic ser_e, busy_e, done_e, rdy_e;
  logic ser_o, busy_o, done_o, rdy_o;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_cycles = 0;
  int done_pulses = 0;
  int done_total  = 0;

  // Reference: a frame is an 11-entry bit list, position p counts cycles into it.
  bit         m_active = 1'b0;
  bit         m_full   = 1'b0;
  bit         m_done   = 1'b0;
  bit         m_acc    = 1'b0;
  int         m_p      = 0;
  int         m_frames = 0;
  logic [7:0] m_cur    = 8'd0;
  logic [7:0] m_buf    = 8'd0;

  uart_tx_fsm #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut (
    .baudOut(clk), .rst(rst), .dataIn(din), .dataValid(dv),
    .dataReady(rdy_e), .serialOutput(ser_e), .busy(busy_e), .frameDone(done_e)
  );

  uart_tx_fsm #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut_odd (
    .baudOut(clk), .rst(rst), .dataIn(din), .dataValid(dv),
    .dataReady(rdy_o), .serialOutput(ser_o), .busy(busy_o), .frameDone(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx, input bit odd);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_full   = 1'b0;
      m_done   = 1'b0;
      m_acc    = 1'b0;
      m_p      = 0;
    end else begin
      bit acc;
      acc    = dv && !m_full;
      m_done = 1'b0;
      if (m_active) begin
        m_p++;
        if (m_p == FL) begin
          m_done = 1'b1;
          m_frames++;
          if (m_full) begin
            m_cur  = m_buf;
            m_full = 1'b0;
            m_p    = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (m_full) begin
        m_cur    = m_buf;
        m_full   = 1'b0;
        m_active = 1'b1;
        m_p      = 0;
      end
      if (acc) begin
        m_buf  = din;
        m_full = 1'b1;
      end
      m_acc = acc;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ser_even", ser_e, m_active ? frame_bit(m_cur, m_p / OS, 1'b0) : 1'b1);
      chk("ser_odd",  ser_o, m_active ? frame_bit(m_cur, m_p / OS, 1'b1) : 1'b1);
      chk("busy",     busy_e, m_active);
      chk("busy_odd", busy_o, m_active);
      chk("done",     done_e, m_done);
      chk("done_odd", done_o, m_done);
      chk("ready",    rdy_e, !m_full);
      chk("ready_odd", rdy_o, !m_full);
      if (busy_e) busy_cycles++;
      if (done_e) begin
        done_pulses++;
        done_total++;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int t;
    t  = 0;
    dv = 1'b1;
    din = b;
    do begin
      @(negedge clk);
      t++;
    end while (!m_acc && t < 1000);
    chk("accept_wait", m_acc, 1'b1);
    dv  = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_active || m_full) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", m_active || m_full, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    #1 rst = 1'b1;
    #2;
    chk("rst_ser",   ser_e, 1'b1);
    chk("rst_busy",  busy_e, 1'b0);
    chk("rst_done",  done_e, 1'b0);
    chk("rst_ready", rdy_e, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    busy_cycles = 0; done_pulses = 0;
    push(8'hA5);
    wait_idle();
    chk("t1_busy_cycles", busy_cycles, FL);
    chk("t1_done_pulses", done_pulses, 1);

    push(8'h07);
    wait_idle();

    busy_cycles = 0; done_pulses = 0;
    push(8'h00);
    push(8'hFF);
    wait_idle();
    chk("t3_busy_cycles", busy_cycles, 2 * FL);
    chk("t3_done_pulses", done_pulses, 2);

    done_pulses = 0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_idle();
    chk("t4_done_pulses", done_pulses, 3);

    push(8'hC3);
    push(8'h3C);
    t = 0;
    while (!(m_active && m_p == 4 * OS + 5) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("t5_reach_d3", m_full, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t5_ser",   ser_e, 1'b1);
    chk("t5_busy",  busy_e, 1'b0);
    chk("t5_ready", rdy_e, 1'b1);
    chk("t5_done",  done_e, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    busy_cycles = 0; done_pulses = 0;
    repeat (250) @(negedge clk);
    chk("t5_busy_after", busy_cycles, 0);
    chk("t5_done_after", done_pulses, 0);

    push(8'h96);
    wait_idle();

    repeat (600) begin
      @(negedge clk);
      dv  = ($urandom_range(0, 2) == 0);
      din = 8'($urandom);
    end
    dv = 1'b0;
    wait_idle();
    chk("frame_total", done_total, m_frames);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- 16x-oversampled UART transmitter, the transmit-side counterpart of the team's UART receiver.
- Serialises one byte per frame: 1 start bit, 8 data bits LSB-first, 1 parity bit, 1 stop bit.
- Has a one-entry holding buffer, so the host can queue the next byte while the current frame is shifting out, giving gap-free back-to-back frames.
- Clocked by the baud-rate generator's oversampled tick; drives the serial line read by the receiver.

Parameters:
- OVERSAMPLE, 16: baudOut cycles per serial bit; must be a power of two ≥ 4.
- PARITY_ODD, 0: 0 = even parity (ones in data+parity is even); 1 = odd parity.

Ports:
- baudOut  input  1  clock, the 16x baud tick; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dataIn  input  8  byte to transmit.
- dataValid  input  1  host offers dataIn this cycle.
- dataReady  output  1  holding buffer empty; a byte is accepted on a rising edge where dataValid && dataReady.
- serialOutput  output  1  serial line, idle high.
- busy  output  1  a frame is in progress (FSM not IDLE).
- frameDone  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset (asynchronous, while rst=1):
  - serialOutput=1, busy=0, frameDone=0, dataReady=1.
  - Holding buffer empty; FSM in IDLE; bit counter and bit index cleared.
  - Asserting rst mid-frame aborts the frame immediately: line returns high, any queued byte is discarded.
- All outputs are registered. dataReady = !bufferFull, taken directly from a register.
- Handshake:
  - Accept: dataValid && dataReady at a rising edge loads dataIn into the buffer and sets bufferFull.
  - dataValid while dataReady=0 is ignored; the host must hold it.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each non-IDLE state lasts exactly OVERSAMPLE cycles, with tick counter 0..OVERSAMPLE-1.
  - The state advances on the edge where the counter equals OVERSAMPLE-1; the counter then wraps to 0.
- IDLE:
  - serialOutput=1.
  - If bufferFull: load the shift register from the buffer, compute parity (XOR of the 8 bits, inverted when PARITY_ODD=1), clear bufferFull, enter START, drive serialOutput=0 — all on the same edge.
- START:
  - serialOutput=0.
  - Exit to DATA with bit index 0; serialOutput=d0.
- DATA:
  - serialOutput=shift[bitIndex].
  - After bitIndex 7 completes, go to PARITY; otherwise increment bitIndex.
- PARITY:
  - serialOutput=parity bit.
  - Exit to STOP; serialOutput=1.
- STOP:
  - serialOutput=1.
  - On the final tick, pulse frameDone=1 for one cycle.
  - If bufferFull: go straight to START (same load actions as in IDLE), so there are no idle cycles between frames.
  - Otherwise go to IDLE.
- busy = (state != IDLE).
- Latency: byte accepted at edge N with FSM idle → start bit begins at edge N+1. Frame length 11*OVERSAMPLE = 176 cycles (default); frameDone is high for the cycle after the frame's final edge.
- Simultaneous events:
  - A drain edge (IDLE/STOP loading from the buffer) and an accept cannot coincide, because dataReady=0 while the buffer is full.
  - dataReady rises the cycle after a drain.
- Data is sampled only at accept; later changes to dataIn do not affect the queued or in-flight frame.
- Counter width: log2(OVERSAMPLE) bits; bitIndex is 3 bits. No other arithmetic.

Test Plan:
1. Reset, then offer 0xA5 once (PARITY_ODD=0) → line samples at mid-bit (tick 8) read 0,1,0,1,0,0,1,0,1, parity 0, stop 1; busy high for 176 cycles; one frameDone pulse; dataReady back to 1 one cycle after acceptance.
2. Send 0x07, even parity, then rebuild with PARITY_ODD=1 → parity bit 1 with even parity and 0 with odd parity; the data bits in both runs are 1,1,1,0,0,0,0,0.
3. Offer 0x00, then hold dataValid with 0xFF → 0xFF accepted during the first frame; its start bit begins on the cycle right after the first stop bit, with no idle gap; total busy 352 cycles; two frameDone pulses.
4. Backpressure: offer 0x11, 0x22, 0x33 continuously → dataReady=0 while the buffer holds 0x22; all three frames transmitted in order, none dropped or duplicated.
5. Assert rst at tick 5 of data bit d3 while a byte is queued → serialOutput=1, busy=0, dataReady=1 immediately (asynchronously); after release the line stays idle and the queued byte is not sent.
6. dataIn changes after acceptance but before the start bit → the transmitted bits match the accepted value, not the changed one.
